hint_decode_ctrl: RTL and testbench
===================================

HINT_DECODE_CTRL -- requirements
Module: hint_decode_ctrl

Interface
REQ-001 SHALL have parameter MLDSA_N, default 256, coefficients per polynomial.
REQ-002 SHALL have parameter MLDSA_K, default 8, polynomials per hint vector.
REQ-003 SHALL have parameter OMEGA, default 75, maximum total hints; encoded_h is OMEGA+MLDSA_K bytes.
REQ-004 SHALL have parameter LANES, default 4, legal values {1,2,4,8}, hint bytes consumed per cycle.
REQ-005 SHALL have parameter COEFF_PER_WR, default 4, coefficients per memory write.
REQ-006 Ports (name direction width meaning), one per line:
 clk  in  1  clock
 reset_n  in  1  reset, asynchronous, active-low
 zeroize  in  1  synchronous clear of all state
 enable  in  1  start pulse, honoured only when idle
 dest_base_addr  in  ABR_MEM_ADDR_WIDTH  first write address
 hintsum_i  in  8  cumulative hintsum byte OMEGA+poly_count
 hint_idx_i  in  LANES*8  hint bytes rd_ptr..rd_ptr+LANES-1, lane 0 in LSBs
 mem_wr_req  out  mem_if_t  write address and rd_wr_en
 done  out  1  both FSMs idle
 error  out  1  sticky malformed-encoding flag
 poly_count  out  $clog2(MLDSA_K+1)  current polynomial
 rd_ptr  out  $clog2(OMEGA+MLDSA_K)  hint byte read pointer
 lane_mask  out  LANES  lanes valid for current polynomial, registered
 bitmap_ptr  out  $clog2(MLDSA_N)  first coefficient of current write
 hint_rd_en  out  1  hint bytes valid for bitmap build
 rst_bitmap  out  1  clear bitmap after a polynomial's last write

Function
REQ-007 Read FSM states SHALL be RD_IDLE, RD_INIT, RD_HINTSUM, RD_EXEC, RD_PAD; write FSM states WR_IDLE, WR_INIT, WR_MEM.
REQ-008 enable in RD_IDLE/WR_IDLE SHALL move both FSMs to *_INIT next cycle, clear error, rd_ptr, poly_count, prev_hintsum, load write address with dest_base_addr.
REQ-009 RD_INIT->RD_HINTSUM SHALL occur when write FSM is in WR_INIT; RD_HINTSUM SHALL last one cycle and latch rem = hintsum_i - prev_hintsum.
REQ-010 RD_HINTSUM SHALL flag error if hintsum_i < prev_hintsum or hintsum_i > OMEGA.
REQ-011 Each RD_EXEC cycle with rem != 0 SHALL assert hint_rd_en, set lane_mask to min(rem,LANES) low ones, advance rd_ptr by min(rem,LANES), reduce rem by the same.
REQ-012 RD_EXEC with rem == 0 SHALL set prev_hintsum = hintsum and go to RD_INIT, or RD_PAD if poly_count == MLDSA_K-1.
REQ-013 Within one polynomial, each valid hint byte SHALL exceed the previous valid one (including across cycles); otherwise error.
REQ-014 RD_PAD SHALL scan bytes rd_ptr..OMEGA-1, LANES per cycle, flag error on any nonzero byte, then go to RD_IDLE; zero-length pad SHALL take one cycle.
REQ-015 WR_INIT->WR_MEM SHALL occur the cycle after hint_rd_en, or on a rem==0 polynomial.
REQ-016 WR_MEM SHALL issue one RW_WRITE per cycle, address incrementing, bitmap_ptr stepping by COEFF_PER_WR, MLDSA_N/COEFF_PER_WR writes per polynomial.
REQ-017 Last write of a polynomial SHALL pulse rst_bitmap, increment poly_count, return to WR_INIT, or WR_IDLE after poly MLDSA_K-1.
REQ-018 On error, both FSMs SHALL go to idle next cycle with no further writes; error SHALL hold until next enable or zeroize.
REQ-019 done SHALL equal read FSM in RD_IDLE and write FSM in WR_IDLE.
REQ-020 enable while busy SHALL be ignored.

Reset
REQ-021 reset_n low or zeroize SHALL return FSMs to idle and zero all registers/outputs; mem_wr_req.rd_wr_en=RW_IDLE, done=1, error=0.
REQ-022 zeroize mid-operation SHALL abort immediately without a final write.

Structure
REQ-023 State enums and derived widths SHALL be in hint_decode_defines_pkg; mem_if_t, mem_rw_mode_e from abr_params_pkg.
REQ-024 Ordering/padding checker SHALL be sub-module hint_decode_check.

Verification
REQ-025 hintsums {2,2,5,5,5,5,5,9}, sorted indices -> 512 writes from dest_base_addr, rd_ptr ends 9, error=0, done=1.
REQ-026 hintsum 7 with LANES=4 -> lane_mask 1111 then 0111, rd_ptr +4 then +3.
REQ-027 poly 3 hintsum_i 4 after prev 6 -> error next cycle, no writes for poly 3, done=1.
REQ-028 nonzero byte at OMEGA-1 with total 10 -> error in RD_PAD, all 512 writes done.
REQ-029 repeated index 0x20,0x20 in one poly -> error; LANES=1 build repeats same result.
REQ-030 zeroize at write 100 -> next cycle RW_IDLE, poly_count 0, done=1.

Source files
------------

// File: rtl/abr_params_pkg.sv
// abr_params_pkg: memory-interface types shared across the abr datapath
// Exports ABR_MEM_ADDR_WIDTH, mem_rw_mode_e (idle/read/write) and mem_if_t (mode + address).
package abr_params_pkg;
    localparam int ABR_MEM_ADDR_WIDTH = 15;
    typedef enum logic [1:0] {RW_IDLE = 2'd0, RW_READ = 2'd1, RW_WRITE = 2'd2} mem_rw_mode_e;
    typedef struct packed {
        mem_rw_mode_e                  rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;
endpackage

// File: rtl/hint_decode_defines_pkg.sv
// hint_decode_defines_pkg: FSM state enums, default sizes and derived-width helpers for the hint decoder
package hint_decode_defines_pkg;
    localparam int HD_MLDSA_N       = 256;
    localparam int HD_MLDSA_K       = 8;
    localparam int HD_OMEGA         = 75;
    localparam int HD_LANES         = 4;
    localparam int HD_COEFF_PER_WR  = 4;
    typedef enum logic [2:0] {RD_IDLE, RD_INIT, RD_HINTSUM, RD_EXEC, RD_PAD} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_INIT, WR_MEM} wr_state_e;
    function automatic int ptr_w(input int omega, input int k);
        return $clog2(omega + k);
    endfunction
    function automatic int poly_w(input int k);
        return $clog2(k + 1);
    endfunction
    function automatic int coeff_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/hint_decode_check.sv
// hint_decode_check: ordering check on hint bytes and zero check on padding bytes
// Ports: clk, reset_n (async, active-low), zeroize (sync clear), clear (new polynomial),
//        chk_en (ordering check this cycle), pad_en (padding check this cycle),
//        mask (valid lanes), data (LANES bytes, lane 0 in LSBs), err (combinational violation).
module hint_decode_check
    import hint_decode_defines_pkg::*;
#(
    parameter int LANES = HD_LANES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               zeroize,
    input  logic               clear,
    input  logic               chk_en,
    input  logic               pad_en,
    input  logic [LANES-1:0]   mask,
    input  logic [LANES*8-1:0] data,
    output logic               err
);
    logic       have_prev, seen, bad;
    logic [7:0] last, hi;
    // Lanes are scanned in order so the running maximum also covers bytes seen in earlier cycles.
    always_comb begin
        bad  = 1'b0;
        seen = have_prev;
        hi   = last;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                bad  = bad | (pad_en ? (data[i*8 +: 8] != 8'h0) : (seen && data[i*8 +: 8] <= hi));
                seen = 1'b1;
                hi   = data[i*8 +: 8];
            end
        end
    end
    assign err = (chk_en || pad_en) && bad;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {have_prev, last} <= '0;
        else if (zeroize || clear) {have_prev, last} <= '0;
        else if (chk_en) begin
            have_prev <= seen;
            last      <= hi;
        end
    end
endmodule

// File: rtl/hint_decode_ctrl.sv
// hint_decode_ctrl: walks an encoded hint vector, validates it and sequences bitmap writes to memory
module hint_decode_ctrl
    import abr_params_pkg::*;
    import hint_decode_defines_pkg::*;
#(
    parameter int MLDSA_N      = HD_MLDSA_N,
    parameter int MLDSA_K      = HD_MLDSA_K,
    parameter int OMEGA        = HD_OMEGA,
    parameter int LANES        = HD_LANES,
    parameter int COEFF_PER_WR = HD_COEFF_PER_WR
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               zeroize,
    input  logic                               enable,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0]      dest_base_addr,
    input  logic [7:0]                         hintsum_i,
    input  logic [LANES*8-1:0]                 hint_idx_i,
    output mem_if_t                            mem_wr_req,
    output logic                               done,
    output logic                               error,
    output logic [poly_w(MLDSA_K)-1:0]         poly_count,
    output logic [ptr_w(OMEGA, MLDSA_K)-1:0]   rd_ptr,
    output logic [LANES-1:0]                   lane_mask,
    output logic [coeff_w(MLDSA_N)-1:0]        bitmap_ptr,
    output logic                               hint_rd_en,
    output logic                               rst_bitmap
);
    localparam int PTRW = ptr_w(OMEGA, MLDSA_K);
    localparam int PCW  = poly_w(MLDSA_K);
    localparam int BPW  = coeff_w(MLDSA_N);
    localparam logic [7:0] LANES_B = 8'(LANES);
    localparam logic [7:0] OMEGA_B = 8'(OMEGA);

    rd_state_e rd_state, rd_next;
    wr_state_e wr_state, wr_next;
    logic [7:0] rem, prev_hs, take, pad_rem;
    logic [LANES-1:0] mask;
    logic [ABR_MEM_ADDR_WIDTH-1:0] wr_addr;
    logic start, in_pad, build_done, last_wr, pad_last, hs_err, chk_err, err_now;

    assign done       = rd_state == RD_IDLE && wr_state == WR_IDLE;
    assign start      = enable && done;
    assign in_pad     = rd_state == RD_PAD;
    assign hint_rd_en = rd_state == RD_EXEC && rem != 8'h0;
    assign build_done = rd_state == RD_EXEC && rem == 8'h0;
    assign last_wr    = wr_state == WR_MEM && bitmap_ptr == BPW'(MLDSA_N - COEFF_PER_WR);
    assign rst_bitmap = last_wr;
    assign pad_rem    = OMEGA_B - 8'(rd_ptr);
    assign pad_last   = pad_rem <= LANES_B;
    assign take       = in_pad ? (pad_last ? pad_rem : LANES_B) : (rem < LANES_B ? rem : LANES_B);
    assign hs_err     = rd_state == RD_HINTSUM && (hintsum_i < prev_hs || hintsum_i > OMEGA_B);
    assign err_now    = hs_err || chk_err;
    assign mem_wr_req.rd_wr_en = (wr_state == WR_MEM && !zeroize) ? RW_WRITE : RW_IDLE;
    assign mem_wr_req.addr     = wr_addr;

    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) mask[i] = 8'(i) < take;
    end

    hint_decode_check #(.LANES(LANES)) u_check (
        .clk     (clk),
        .reset_n (reset_n),
        .zeroize (zeroize),
        .clear   (rd_state == RD_HINTSUM),
        .chk_en  (hint_rd_en),
        .pad_en  (in_pad),
        .mask    (mask),
        .data    (hint_idx_i),
        .err     (chk_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
        end else begin
            rd_state <= zeroize ? RD_IDLE : rd_next;
            wr_state <= zeroize ? WR_IDLE : wr_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        wr_next = wr_state;
        case (rd_state)
            RD_IDLE:    rd_next = start ? RD_INIT : RD_IDLE;
            RD_INIT:    rd_next = wr_state == WR_INIT ? RD_HINTSUM : RD_INIT;
            RD_HINTSUM: rd_next = RD_EXEC;
            RD_EXEC:    rd_next = !build_done ? RD_EXEC : (poly_count == PCW'(MLDSA_K - 1) ? RD_PAD : RD_INIT);
            RD_PAD:     rd_next = pad_last ? RD_IDLE : RD_PAD;
            default:    rd_next = RD_IDLE;
        endcase
        case (wr_state)
            WR_IDLE: wr_next = start ? WR_INIT : WR_IDLE;
            WR_INIT: wr_next = build_done ? WR_MEM : WR_INIT;
            WR_MEM:  wr_next = !last_wr ? WR_MEM : (poly_count == PCW'(MLDSA_K - 1) ? WR_IDLE : WR_INIT);
            default: wr_next = WR_IDLE;
        endcase
        if (err_now) rd_next = RD_IDLE;
        if (err_now && !in_pad) wr_next = WR_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {error, rd_ptr, poly_count, prev_hs, rem, wr_addr, bitmap_ptr, lane_mask} <= '0;
        else if (zeroize) {error, rd_ptr, poly_count, prev_hs, rem, wr_addr, bitmap_ptr, lane_mask} <= '0;
        else begin
            lane_mask <= hint_rd_en ? mask : '0;
            if (start) begin
                error      <= 1'b0;
                rd_ptr     <= '0;
                poly_count <= '0;
                prev_hs    <= '0;
                rem        <= '0;
                wr_addr    <= dest_base_addr;
                bitmap_ptr <= '0;
            end else begin
                if (err_now) error <= 1'b1;
                if (rd_state == RD_HINTSUM) rem <= hintsum_i - prev_hs;
                if (hint_rd_en) rem <= rem - take;
                if (hint_rd_en || in_pad) rd_ptr <= rd_ptr + PTRW'(take);
                if (build_done) prev_hs <= hintsum_i;
                if (wr_state == WR_MEM) begin
                    wr_addr    <= wr_addr + ABR_MEM_ADDR_WIDTH'(1);
                    bitmap_ptr <= last_wr ? '0 : bitmap_ptr + BPW'(COEFF_PER_WR);
                end
                if (last_wr) poly_count <= poly_count + PCW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hint_decode_ctrl.sv
// tb_hint_decode_ctrl: directed bench for hint_decode_ctrl, one LANES=4 and one LANES=1 instance
module tb_hint_decode_ctrl;
    import abr_params_pkg::*;
    localparam int OM = 75;
    localparam logic [14:0] BASE = 15'h100;

    logic clk = 1'b0, reset_n = 1'b0, zeroize = 1'b0, enable = 1'b0;
    logic [7:0] enc [0:82];

    logic [7:0] hs0, hs1, idx1;
    logic [31:0] idx0;
    mem_if_t req0, req1;
    logic done0, done1, err0, err1, hre0, hre1, rb0, rb1;
    logic [3:0] pc0, pc1, lm0;
    logic [0:0] lm1;
    logic [6:0] rp0, rp1;
    logic [7:0] bp0, bp1;

    int checks = 0, errors = 0;
    int w0 = 0, w1 = 0, bad0 = 0, bad1 = 0, rbn0 = 0, wae0 = 0, lmn0 = 0, lmn1 = 0;
    int sw0 = 0, sw1 = 0, sbad0, sbad1, srb0, swae0, slm0, slm1;
    logic [3:0] lmv [0:255];
    logic [6:0] rpv [0:255];
    logic [6:0] rp448 = '0;

    always #5 clk = ~clk;

    hint_decode_ctrl #(.LANES(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .enable(enable),
        .dest_base_addr(BASE), .hintsum_i(hs0), .hint_idx_i(idx0), .mem_wr_req(req0),
        .done(done0), .error(err0), .poly_count(pc0), .rd_ptr(rp0), .lane_mask(lm0),
        .bitmap_ptr(bp0), .hint_rd_en(hre0), .rst_bitmap(rb0)
    );

    hint_decode_ctrl #(.LANES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .enable(enable),
        .dest_base_addr(BASE), .hintsum_i(hs1), .hint_idx_i(idx1), .mem_wr_req(req1),
        .done(done1), .error(err1), .poly_count(pc1), .rd_ptr(rp1), .lane_mask(lm1),
        .bitmap_ptr(bp1), .hint_rd_en(hre1), .rst_bitmap(rb1)
    );

    // Encoded-hint memory model: bytes at rd_ptr.. and the hintsum byte of the current polynomial.
    always_comb begin
        idx0 = '0;
        for (int i = 0; i < 4; i++) idx0[i*8 +: 8] = (int'(rp0) + i < 83) ? enc[int'(rp0) + i] : 8'h0;
        idx1 = (int'(rp1) < 83) ? enc[int'(rp1)] : 8'h0;
        hs0  = (pc0 < 4'd8) ? enc[OM + int'(pc0)] : 8'h0;
        hs1  = (pc1 < 4'd8) ? enc[OM + int'(pc1)] : 8'h0;
    end

    always @(negedge clk) begin
        if (req0.rd_wr_en == RW_WRITE) begin
            if (req0.addr != BASE + 15'(w0 - sw0) || bp0 != 8'(((w0 - sw0) % 64) * 4)) bad0 <= bad0 + 1;
            if (w0 - sw0 == 448) rp448 <= rp0;
            if (err0) wae0 <= wae0 + 1;
            w0 <= w0 + 1;
        end
        if (req1.rd_wr_en == RW_WRITE) begin
            if (req1.addr != BASE + 15'(w1 - sw1) || bp1 != 8'(((w1 - sw1) % 64) * 4)) bad1 <= bad1 + 1;
            w1 <= w1 + 1;
        end
        if (rb0) rbn0 <= rbn0 + 1;
        if (lm0 != 4'h0) begin
            lmv[lmn0 & 255] <= lm0;
            rpv[lmn0 & 255] <= rp0;
            lmn0 <= lmn0 + 1;
        end
        if (lm1 != 1'b0) lmn1 <= lmn1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int hs [8]);
        int p, k;
        for (int i = 0; i < 83; i++) enc[i] = 8'h0;
        p = 0;
        for (int j = 0; j < 8; j++) begin
            k = 0;
            for (int i = p; i < hs[j]; i++) begin
                enc[i] = 8'(16 + 7 * k);
                k++;
            end
            if (hs[j] > p) p = hs[j];
            enc[OM + j] = 8'(hs[j]);
        end
    endtask

    task automatic snap();
        sw0 = w0; sw1 = w1; sbad0 = bad0; sbad1 = bad1; srb0 = rbn0; swae0 = wae0;
        slm0 = lmn0; slm1 = lmn1;
    endtask

    task automatic run(input bit mid_en);
        int c;
        snap();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        c = 0;
        while (!(done0 && done1) && c < 3000) begin
            enable = mid_en && (w0 - sw0 == 50);
            @(posedge clk); #1;
            c++;
        end
        enable = 1'b0;
        chk("run_timeout", {31'b0, done0 && done1}, 1);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 83; i++) enc[i] = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done0}, 1);
        chk("rst_error", {31'b0, err0}, 0);
        chk("rst_rw", {30'b0, req0.rd_wr_en}, {30'b0, RW_IDLE});
        chk("rst_poly", {28'b0, pc0}, 0);
        chk("rst_rdptr", {25'b0, rp0}, 0);
        chk("rst_lanes", {28'b0, lm0}, 0);
        reset_n = 1'b1;

        load('{2, 2, 5, 5, 5, 5, 5, 9});
        run(1'b1);
        chk("s1_writes0", w0 - sw0, 512);
        chk("s1_writes1", w1 - sw1, 512);
        chk("s1_addr0", bad0 - sbad0, 0);
        chk("s1_addr1", bad1 - sbad1, 0);
        chk("s1_err0", {31'b0, err0}, 0);
        chk("s1_err1", {31'b0, err1}, 0);
        chk("s1_rstbmp", rbn0 - srb0, 8);
        chk("s1_rdptr_pad", {25'b0, rp448}, 9);
        chk("s1_rdptr_end0", {25'b0, rp0}, OM);
        chk("s1_rdptr_end1", {25'b0, rp1}, OM);
        chk("s1_poly", {28'b0, pc0}, 8);

        load('{7, 7, 7, 7, 7, 7, 7, 7});
        run(1'b0);
        chk("s2_mask_a", {28'b0, lmv[slm0 & 255]}, 32'hF);
        chk("s2_mask_b", {28'b0, lmv[(slm0 + 1) & 255]}, 32'h7);
        chk("s2_ptr_a", {25'b0, rpv[slm0 & 255]}, 4);
        chk("s2_ptr_b", {25'b0, rpv[(slm0 + 1) & 255]}, 7);
        chk("s2_build_cyc0", lmn0 - slm0, 2);
        chk("s2_build_cyc1", lmn1 - slm1, 7);
        chk("s2_writes0", w0 - sw0, 512);
        chk("s2_err0", {31'b0, err0}, 0);

        load('{1, 3, 6, 4, 4, 4, 4, 4});
        run(1'b0);
        chk("s3_writes0", w0 - sw0, 192);
        chk("s3_writes1", w1 - sw1, 192);
        chk("s3_err0", {31'b0, err0}, 1);
        chk("s3_err1", {31'b0, err1}, 1);
        chk("s3_wr_after_err", wae0 - swae0, 0);
        chk("s3_poly", {28'b0, pc0}, 3);

        load('{1, 2, 3, 4, 5, 6, 8, 10});
        enc[OM - 1] = 8'h01;
        run(1'b0);
        chk("s4_err0", {31'b0, err0}, 1);
        chk("s4_err1", {31'b0, err1}, 1);
        chk("s4_writes0", w0 - sw0, 512);
        chk("s4_writes1", w1 - sw1, 512);

        load('{2, 2, 2, 2, 2, 2, 2, 2});
        enc[0] = 8'h20;
        enc[1] = 8'h20;
        run(1'b0);
        chk("s5_err0", {31'b0, err0}, 1);
        chk("s5_err1", {31'b0, err1}, 1);
        chk("s5_writes0", w0 - sw0, 0);
        chk("s5_writes1", w1 - sw1, 0);

        load('{2, 2, 5, 5, 5, 5, 5, 9});
        snap();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        c = 0;
        while (w0 - sw0 < 100 && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("s6_reach100", {31'b0, w0 - sw0 == 100}, 1);
        zeroize = 1'b1;
        @(posedge clk); #1 zeroize = 1'b0;
        chk("s6_rw", {30'b0, req0.rd_wr_en}, {30'b0, RW_IDLE});
        chk("s6_poly", {28'b0, pc0}, 0);
        chk("s6_done0", {31'b0, done0}, 1);
        chk("s6_done1", {31'b0, done1}, 1);
        chk("s6_rdptr", {25'b0, rp0}, 0);
        @(posedge clk); #1;
        chk("s6_writes", w0 - sw0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
